term_ctl: RTL and testbench
===========================

TERM_CTL -- requirements
Module: term_ctl

Interface
REQ-001 Parameter COLS, default 80, meaning text columns per row.
REQ-002 Parameter ROWS, default 30, meaning text rows per screen.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 din  input  8  character byte from upstream 2:1 byte arbiter.
REQ-006 dinv  input  1  din valid, one-cycle strobe per byte; no backpressure to upstream.
REQ-007 wa  output  12  text RAM write address = prow*COLS + col.
REQ-008 wd  output  8  text RAM write data.
REQ-009 we  output  1  text RAM write enable, one cycle per cell written.
REQ-010 top_row  output  5  physical RAM row shown as screen row 0 (scroll base) for the VGA reader.
REQ-011 cur_row  output  5  logical cursor row, 0..ROWS-1.
REQ-012 cur_col  output  7  cursor column, 0..COLS-1.
REQ-013 busy  output  1  high when FSM not IDLE or FIFO non-empty.
REQ-014 ovf  output  1  sticky: an input byte was dropped.

Function
REQ-015 Input FIFO SHALL be 4 bytes deep; on dinv, byte pushed if count<4 or a pop occurs same cycle; otherwise dropped and ovf set.
REQ-016 FSM states SHALL be IDLE, EXEC, CLR; IDLE with FIFO non-empty pops oldest byte into register ch and goes EXEC.
REQ-017 Physical row SHALL be prow = top_row+cur_row, minus ROWS if result >= ROWS.
REQ-018 EXEC, ch in 0x20..0x7E: we=1, wd=ch, wa at (prow,cur_col); then cur_col+1, or if cur_col==COLS-1 then cur_col=0 and newline.
REQ-019 EXEC, ch==0x0A (LF): newline; no write.
REQ-020 EXEC, ch==0x0D (CR): cur_col=0; no write.
REQ-021 EXEC, ch==0x08 (BS): if cur_col>0, cur_col-1 and write 0x20 at new position; at cur_col 0 no write, no change.
REQ-022 EXEC, any other code: ignored, no write, cursor unchanged.
REQ-023 Newline: if cur_row<ROWS-1, cur_row+1, return IDLE; else cur_row stays ROWS-1, top_row+1 (wraps ROWS-1 -> 0), go CLR.
REQ-024 CLR SHALL write 0x20 to all COLS cells of the new bottom physical row, col 0..COLS-1, one per cycle, then return IDLE; no FIFO pops during CLR.
REQ-025 wa/wd/we SHALL be registered; byte sampled with FIFO empty and FSM IDLE produces we exactly 2 cycles after the dinv cycle.
REQ-026 Throughput: one byte per 2 cycles when no CLR; FIFO continues accepting during EXEC and CLR.
REQ-027 Wrap-then-scroll (printable at last column of last row): char written first, then CLR of exactly one row.
REQ-028 we SHALL never be high in IDLE; wa SHALL always be < COLS*ROWS.

Reset
REQ-029 resetn low SHALL set: FSM IDLE, FIFO empty, cur_row=0, cur_col=0, top_row=0, we=0, wa=0, wd=0, ovf=0, busy=0.
REQ-030 Reset mid-EXEC or mid-CLR SHALL abandon the operation with no further writes; text RAM is not cleared by reset.
REQ-031 dinv during reset SHALL be ignored.

Verification
REQ-032 Reset, push 0x41 -> one write wa=0 wd=0x41, 2 cycles after dinv; cur_col=1, busy falls.
REQ-033 80 bytes 0x30 from (0,0) -> writes wa=0..79, final cursor row 1 col 0, top_row 0.
REQ-034 Cursor (29,3), top_row 0, push 0x0A -> top_row=1, 80 writes 0x20 at wa=0..79, cur_row 29 col 3.
REQ-035 Cursor col 5 push 0x08 -> write 0x20 at col 4, cur_col 4; col 0 push 0x08, 0x0D, 0x07 -> no writes, cursor unchanged.
REQ-036 During CLR push 5 bytes 0x61..0x65 -> ovf=1, after CLR writes 0x61..0x64 in order, 0x65 never written.
REQ-037 Assert resetn low at CLR cycle 10 -> we low next cycle, all outputs at reset values, no writes after.

Source files
------------

// File: rtl/term_ctl.sv
// term_ctl: character terminal controller.
// Accepts character bytes through a 4-deep input FIFO and interprets them:
// printable characters, LF, CR and BS. It writes the result into a
// COLS x ROWS text RAM. When a newline happens on the last row, the screen
// scrolls by moving top_row, and the row that becomes the new bottom row is
// cleared with spaces.
//
// Ports:
//   clk      - single clock; all logic on the rising edge
//   resetn   - synchronous active-low reset
//   din/dinv - input byte and its one-cycle valid strobe (no backpressure)
//   wa/wd/we - registered text RAM write port (wa = prow*COLS + col)
//   top_row  - physical RAM row shown as screen row 0 (scroll base)
//   cur_row  - logical cursor row
//   cur_col  - cursor column
//   busy     - FSM not idle or FIFO not empty
//   ovf      - sticky flag: an input byte was dropped
module term_ctl #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  din,
    input  logic        dinv,
    output logic [11:0] wa,
    output logic [7:0]  wd,
    output logic        we,
    output logic [4:0]  top_row,
    output logic [4:0]  cur_row,
    output logic [6:0]  cur_col,
    output logic        busy,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, EXEC, CLR} state_t;

    state_t      state_q, state_d;
    logic [7:0]  ch_q, ch_d;
    logic [4:0]  cur_row_q, cur_row_d;
    logic [6:0]  cur_col_q, cur_col_d;
    logic [4:0]  top_row_q, top_row_d;
    logic [6:0]  clr_col_q, clr_col_d;
    logic [11:0] clr_base_q, clr_base_d;
    logic [11:0] wa_q, wa_d;
    logic [7:0]  wd_q, wd_d;
    logic        we_q, we_d;
    logic        ovf_q, ovf_d;

    logic [7:0]  fifo_q [4];
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        pop;
    logic        push;
    logic [7:0]  head;
    logic [5:0]  row_sum;
    logic [4:0]  prow;
    logic [11:0] row_base;
    logic        nl;

    function automatic logic is_print(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

    // Pops only happen in IDLE, so CLR never drains the FIFO. A push into a
    // full FIFO is still accepted when a pop frees a slot in the same cycle.
    assign pop  = (state_q == IDLE) && (cnt_q != 3'd0);
    assign push = dinv && ((cnt_q < 3'd4) || pop);
    assign head = fifo_q[rd_ptr_q];

    always_comb begin
        row_sum = {1'b0, top_row_q} + {1'b0, cur_row_q};
        if (row_sum >= 6'(ROWS)) begin
            prow = 5'(row_sum - 6'(ROWS));
        end else begin
            prow = row_sum[4:0];
        end
        row_base = 12'(prow) * 12'(COLS);
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        cur_row_d  = cur_row_q;
        cur_col_d  = cur_col_q;
        top_row_d  = top_row_q;
        clr_col_d  = clr_col_q;
        clr_base_d = clr_base_q;
        wa_d       = wa_q;
        wd_d       = wd_q;
        we_d       = 1'b0;
        nl         = 1'b0;
        ovf_d      = ovf_q | (dinv && !push);
        rd_ptr_d   = rd_ptr_q + 2'(pop);
        wr_ptr_d   = wr_ptr_q + 2'(push);
        cnt_d      = cnt_q + 3'(push) - 3'(pop);

        case (state_q)
            IDLE: begin
                if (pop) begin
                    ch_d    = head;
                    state_d = EXEC;
                    // The write is issued on the pop edge so that we is only
                    // ever high while the FSM is in EXEC or CLR.
                    if (is_print(head)) begin
                        we_d = 1'b1;
                        wd_d = head;
                        wa_d = row_base + 12'(cur_col_q);
                    end else if (head == 8'h08 && cur_col_q != 7'd0) begin
                        we_d = 1'b1;
                        wd_d = 8'h20;
                        wa_d = row_base + 12'(cur_col_q) - 12'd1;
                    end
                end
            end
            EXEC: begin
                state_d = IDLE;
                if (is_print(ch_q)) begin
                    if (cur_col_q == 7'(COLS - 1)) begin
                        cur_col_d = 7'd0;
                        nl        = 1'b1;
                    end else begin
                        cur_col_d = cur_col_q + 7'd1;
                    end
                end else if (ch_q == 8'h0A) begin
                    nl = 1'b1;
                end else if (ch_q == 8'h0D) begin
                    cur_col_d = 7'd0;
                end else if (ch_q == 8'h08 && cur_col_q != 7'd0) begin
                    cur_col_d = cur_col_q - 7'd1;
                end

                if (nl) begin
                    if (cur_row_q < 5'(ROWS - 1)) begin
                        cur_row_d = cur_row_q + 5'd1;
                    end else begin
                        // Scroll: the old top row becomes the new bottom row.
                        // Column 0 of it is cleared on this edge and the rest
                        // in CLR.
                        top_row_d  = (top_row_q == 5'(ROWS - 1)) ? 5'd0 : top_row_q + 5'd1;
                        clr_base_d = 12'(top_row_q) * 12'(COLS);
                        clr_col_d  = 7'd1;
                        we_d       = 1'b1;
                        wd_d       = 8'h20;
                        wa_d       = 12'(top_row_q) * 12'(COLS);
                        state_d    = CLR;
                    end
                end
            end
            CLR: begin
                if (clr_col_q < 7'(COLS)) begin
                    we_d      = 1'b1;
                    wd_d      = 8'h20;
                    wa_d      = clr_base_q + 12'(clr_col_q);
                    clr_col_d = clr_col_q + 7'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            ch_q       <= 8'd0;
            cur_row_q  <= 5'd0;
            cur_col_q  <= 7'd0;
            top_row_q  <= 5'd0;
            clr_col_q  <= 7'd0;
            clr_base_q <= 12'd0;
            wa_q       <= 12'd0;
            wd_q       <= 8'd0;
            we_q       <= 1'b0;
            ovf_q      <= 1'b0;
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
            cnt_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            cur_row_q  <= cur_row_d;
            cur_col_q  <= cur_col_d;
            top_row_q  <= top_row_d;
            clr_col_q  <= clr_col_d;
            clr_base_q <= clr_base_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            we_q       <= we_d;
            ovf_q      <= ovf_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= din;
            end
        end
    end

    assign wa      = wa_q;
    assign wd      = wd_q;
    assign we      = we_q;
    assign top_row = top_row_q;
    assign cur_row = cur_row_q;
    assign cur_col = cur_col_q;
    assign busy    = (state_q != IDLE) || (cnt_q != 3'd0);
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_term_ctl.sv
// tb_term_ctl: self-checking bench for term_ctl.
// A table of single-byte vectors, hand-written multi-cycle sequences
// (latency, line wrap, scroll clear, FIFO overflow, reset mid-clear), and
// random bursts compared against a cursor/screen reference model.
module tb_term_ctl;
    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  din = 8'd0;
    logic        dinv = 1'b0;
    logic [11:0] wa;
    logic [7:0]  wd;
    logic        we;
    logic [4:0]  top_row;
    logic [4:0]  cur_row;
    logic [6:0]  cur_col;
    logic        busy;
    logic        ovf;

    always #5 clk = ~clk;

    term_ctl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .resetn(resetn), .din(din), .dinv(dinv),
        .wa(wa), .wd(wd), .we(we), .top_row(top_row),
        .cur_row(cur_row), .cur_col(cur_col), .busy(busy), .ovf(ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [19:0] act_q[$];
    logic [19:0] exp_q[$];
    int m_row, m_col, m_top;

    typedef struct {
        int         pre;
        logic [7:0] ch;
        int         nw;
        int         ewa;
        int         ewd;
        int         row;
        int         col;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Every write is recorded, including any during reset.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            act_q.push_back({wa, wd});
            check("wa_range", (int'(wa) < COLS * ROWS) ? 1 : 0, 1);
        end
    end

    // Reference model: cursor in logical coordinates, physical row by modulo.
    task automatic m_write(input int row, input int col, input logic [7:0] data);
        exp_q.push_back({12'(((m_top + row) % ROWS) * COLS + col), data});
    endtask

    task automatic m_newline();
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
            m_top = (m_top + 1) % ROWS;
            for (int c = 0; c < COLS; c++) m_write(ROWS - 1, c, 8'h20);
        end
    endtask

    task automatic m_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_write(m_row, m_col, b);
            if (m_col == COLS - 1) begin
                m_col = 0;
                m_newline();
            end else begin
                m_col++;
            end
        end else if (b == 8'h0A) begin
            m_newline();
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08 && m_col > 0) begin
            m_col--;
            m_write(m_row, m_col, 8'h20);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        dinv   = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        m_row = 0; m_col = 0; m_top = 0;
        @(negedge clk);
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [7:0] b);
        din = b; dinv = 1'b1;
        @(negedge clk);
        dinv = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int k = 0;
        while (busy !== 1'b0 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check({name, "_idle"}, 32'(busy), 0);
    endtask

    task automatic compare_writes(input string name);
        int n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            logic bad = (act_q[i] !== exp_q[i]);
            check($sformatf("%s_w%0d", name, i), act_q[i], exp_q[i]);
            if (bad) break;
        end
        check({name, "_nwrites"}, act_q.size(), exp_q.size());
        act_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [7:0] pick_byte();
        int r = $urandom_range(0, 99);
        if (r < 25) return 8'h0A;
        if (r < 30) return 8'h0D;
        if (r < 38) return 8'h08;
        if (r < 43) return 8'($urandom_range(0, 31));
        if (r < 48) return 8'($urandom_range(127, 255));
        return 8'($urandom_range(32, 126));
    endfunction

    initial begin
        logic [7:0] b;
        int len;

        vecs[0]  = '{0,  8'h41, 1, 0,  8'h41, 0, 1};
        vecs[1]  = '{5,  8'h08, 1, 4,  8'h20, 0, 4};
        vecs[2]  = '{0,  8'h08, 0, 0,  0,     0, 0};
        vecs[3]  = '{0,  8'h0D, 0, 0,  0,     0, 0};
        vecs[4]  = '{0,  8'h07, 0, 0,  0,     0, 0};
        vecs[5]  = '{5,  8'h0D, 0, 0,  0,     0, 0};
        vecs[6]  = '{79, 8'h7E, 1, 79, 8'h7E, 1, 0};
        vecs[7]  = '{3,  8'h0A, 0, 0,  0,     1, 3};
        vecs[8]  = '{2,  8'h1F, 0, 0,  0,     0, 2};
        vecs[9]  = '{2,  8'h7F, 0, 0,  0,     0, 2};
        vecs[10] = '{2,  8'h20, 1, 2,  8'h20, 0, 3};
        vecs[11] = '{78, 8'h08, 1, 77, 8'h20, 0, 77};

        // Reset values (dinv held during reset must be ignored).
        resetn = 1'b0;
        din = 8'h55; dinv = 1'b1;
        repeat (3) @(negedge clk);
        dinv = 1'b0;
        check("rst_we", 32'(we), 0);
        check("rst_wa", 32'(wa), 0);
        check("rst_wd", 32'(wd), 0);
        check("rst_top", 32'(top_row), 0);
        check("rst_row", 32'(cur_row), 0);
        check("rst_col", 32'(cur_col), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(ovf), 0);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_release_busy", 32'(busy), 0);
        act_q.delete();

        // First-write latency: we exactly 2 cycles after the dinv cycle.
        din = 8'h41; dinv = 1'b1;
        @(negedge clk);
        dinv = 1'b0;
        check("lat_we_c1", 32'(we), 0);
        @(negedge clk);
        check("lat_we_c2", 32'(we), 1);
        check("lat_wa", 32'(wa), 0);
        check("lat_wd", 32'(wd), 8'h41);
        @(negedge clk);
        check("lat_we_c3", 32'(we), 0);
        check("lat_busy", 32'(busy), 0);
        check("lat_col", 32'(cur_col), 1);
        $display("[TB] latency sequence done");

        // Table-driven single-byte vectors.
        for (int v = 0; v < 12; v++) begin
            do_reset();
            repeat (vecs[v].pre) send(8'h30);
            wait_idle($sformatf("vec%0d_pre", v), 50);
            act_q.delete();
            send(vecs[v].ch);
            wait_idle($sformatf("vec%0d", v), 50);
            check($sformatf("vec%0d_nw", v), act_q.size(), vecs[v].nw);
            if (vecs[v].nw > 0 && act_q.size() > 0)
                check($sformatf("vec%0d_write", v), act_q[0], {12'(vecs[v].ewa), 8'(vecs[v].ewd)});
            check($sformatf("vec%0d_row", v), 32'(cur_row), vecs[v].row);
            check($sformatf("vec%0d_col", v), 32'(cur_col), vecs[v].col);
            $display("[TB] vec %0d ch=0x%02h writes=%0d row=%0d col=%0d", v, vecs[v].ch, act_q.size(), cur_row, cur_col);
        end

        // 80 characters fill row 0 and wrap to row 1.
        do_reset();
        repeat (80) send(8'h30);
        wait_idle("fill", 50);
        for (int i = 0; i < 80; i++) exp_q.push_back({12'(i), 8'h30});
        compare_writes("fill");
        check("fill_row", 32'(cur_row), 1);
        check("fill_col", 32'(cur_col), 0);
        check("fill_top", 32'(top_row), 0);
        $display("[TB] fill row sequence done");

        // LF on the last row scrolls and clears the old top row.
        do_reset();
        repeat (29) send(8'h0A);
        repeat (3) send(8'h30);
        wait_idle("scroll_pre", 50);
        act_q.delete();
        send(8'h0A);
        wait_idle("scroll", 300);
        for (int i = 0; i < 80; i++) exp_q.push_back({12'(i), 8'h20});
        compare_writes("scroll");
        check("scroll_top", 32'(top_row), 1);
        check("scroll_row", 32'(cur_row), 29);
        check("scroll_col", 32'(cur_col), 3);
        $display("[TB] scroll sequence done");

        // Five bytes pushed during CLR: fifth dropped, ovf set.
        din = 8'h0A; dinv = 1'b1;
        @(negedge clk);
        dinv = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            din = 8'h61 + 8'(i); dinv = 1'b1;
            @(negedge clk);
        end
        dinv = 1'b0;
        check("ovf_set", 32'(ovf), 1);
        wait_idle("ovf", 300);
        for (int i = 0; i < 80; i++) exp_q.push_back({12'(80 + i), 8'h20});
        for (int i = 0; i < 4; i++) exp_q.push_back({12'(83 + i), 8'h61 + 8'(i)});
        compare_writes("ovf");
        check("ovf_top", 32'(top_row), 2);
        check("ovf_col", 32'(cur_col), 7);
        check("ovf_sticky", 32'(ovf), 1);
        $display("[TB] overflow sequence done");

        // Reset during CLR abandons the clear.
        do_reset();
        repeat (29) send(8'h0A);
        wait_idle("rclr_pre", 50);
        act_q.delete();
        din = 8'h0A; dinv = 1'b1;
        @(negedge clk);
        dinv = 1'b0;
        for (int k = 0; k < 60 && act_q.size() < 10; k++) @(negedge clk);
        check("rclr_reached", (act_q.size() >= 10) ? 1 : 0, 1);
        resetn = 1'b0;
        din = 8'h41; dinv = 1'b1;
        @(negedge clk);
        check("rclr_we", 32'(we), 0);
        check("rclr_wa", 32'(wa), 0);
        check("rclr_wd", 32'(wd), 0);
        check("rclr_top", 32'(top_row), 0);
        check("rclr_row", 32'(cur_row), 0);
        check("rclr_col", 32'(cur_col), 0);
        check("rclr_busy", 32'(busy), 0);
        check("rclr_ovf", 32'(ovf), 0);
        act_q.delete();
        @(negedge clk);
        resetn = 1'b1; dinv = 1'b0;
        repeat (100) @(negedge clk);
        check("rclr_nowrites", act_q.size(), 0);
        check("rclr_busy_after", 32'(busy), 0);
        $display("[TB] reset-during-clear sequence done");

        // Random bursts against the reference model.
        do_reset();
        for (int t = 0; t < 60; t++) begin
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
                b = pick_byte();
                m_byte(b);
                din = b; dinv = 1'b1;
                @(negedge clk);
            end
            dinv = 1'b0;
            wait_idle($sformatf("rnd%0d", t), 400);
            $display("[TB] burst %0d len=%0d writes=%0d row=%0d col=%0d top=%0d", t, len, act_q.size(), cur_row, cur_col, top_row);
            compare_writes($sformatf("rnd%0d", t));
            check($sformatf("rnd%0d_row", t), 32'(cur_row), m_row);
            check($sformatf("rnd%0d_col", t), 32'(cur_col), m_col);
            check($sformatf("rnd%0d_top", t), 32'(top_row), m_top);
            check($sformatf("rnd%0d_ovf", t), 32'(ovf), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
